// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
// Used by both uart_rx_os and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-byte handshake between uart_rx_os (master) and its consumer (slave).
interface uart_rx_os_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data;
    logic                      data_valid;
    logic                      data_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output data, data_valid, frame_err, overrun,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, frame_err, overrun,
        output data_ready
    );

endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick divider: one-clk tick every DIV clks, restartable via clr.
module uart_os_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with internal oversampling, start-bit validation,
// stop-bit check and a valid/ready byte output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int baudrate   = 115200,
    parameter int clkHz      = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_in,
    uart_rx_os_if.master bus
);

    localparam int DIV = clkHz / (baudrate * OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_DATA_BITS);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_os: clkHz/(baudrate*OVERSAMPLE) must be >= 2");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx_os: OVERSAMPLE must be even and >= 8");
    end

    logic                      sync1, rx_s, rx_d;
    logic                      tick, clr;
    rx_state_t                 state, state_n;
    logic [OSW-1:0]            os_cnt, os_cnt_n;
    logic [BW-1:0]             bit_cnt, bit_cnt_n;
    logic                      shift_en, stop_smp;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] data_r;
    logic                      data_valid_r, frame_err_r, overrun_r;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // rx_d lags rx_s by one clk so IDLE sees a true falling edge only
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_cnt_n = bit_cnt;
        clr       = 1'b0;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    clr      = 1'b1;
                    os_cnt_n = '0;
                    state_n  = START;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt == OSW'(OVERSAMPLE / 2 - 1)) begin
                        os_cnt_n  = '0;
                        bit_cnt_n = '0;
                        state_n   = rx_s ? IDLE : DATA;
                    end else begin
                        os_cnt_n = os_cnt + OSW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt == OSW'(OVERSAMPLE - 1)) begin
                        os_cnt_n = '0;
                        shift_en = 1'b1;
                        if (bit_cnt == BW'(UART_DATA_BITS - 1)) begin
                            state_n = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + BW'(1);
                        end
                    end else begin
                        os_cnt_n = os_cnt + OSW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt == OSW'(OVERSAMPLE - 1)) begin
                        os_cnt_n = '0;
                        stop_smp = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        os_cnt_n = os_cnt + OSW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        end
    end

    // A same-cycle accept frees the slot, so a new byte can replace it without overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r       <= '0;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (data_valid_r && bus.data_ready) begin
                data_valid_r <= 1'b0;
            end
            if (stop_smp) begin
                if (!rx_s) begin
                    frame_err_r <= 1'b1;
                end else if (!data_valid_r || bus.data_ready) begin
                    data_r       <= shreg;
                    data_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    assign bus.data       = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: 8N1 line BFM, frame-level reference model and
// scoreboard monitor on the byte handshake and error pulses.
module tb_uart_rx_os;
    import uart_pkg::*;

    // Reduced clock so a bit is 256 clks (DIV=16) and the run stays short
    localparam int BAUD     = 115200;
    localparam int CLK_HZ   = 29_491_200;
    localparam int OS       = 16;
    localparam int DIV      = CLK_HZ / (BAUD * OS);
    localparam int BIT      = OS * DIV;
    localparam int BIT_FAST = (BIT * 100 + 51) / 102;
    localparam int BIT_SLOW = (BIT * 100 + 49) / 98;
    localparam int LAT      = 4 + (OS / 2 + 9 * OS) * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;

    uart_rx_os_if bus ();

    uart_rx_os #(
        .baudrate   (BAUD),
        .clkHz      (CLK_HZ),
        .OVERSAMPLE (OS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [7:0] data_q[$];
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    bit         model_full = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level model: what one complete frame should produce at the handshake
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            exp_ferr++;
        end else if (model_full && !bus.data_ready) begin
            exp_ovr++;
        end else begin
            data_q.push_back(b);
            if (!bus.data_ready) model_full = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bclk);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = f[i];
            step(bclk);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop_ok, input int bclk);
        model_frame(b, stop_ok);
        send_frame(b, stop_ok, bclk);
    endtask

    task automatic measure_latency();
        int c;
        c = 0;
        while (!bus.data_valid && c < 12 * BIT) begin
            @(negedge clk);
            c++;
        end
        check("latency_in_window", 32'((c >= LAT - 1) && (c <= LAT + 1)), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_valid && bus.data_ready) begin
                if (data_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", bus.data);
                end else begin
                    check("rx_byte", 32'(bus.data), 32'(data_q.pop_front()));
                end
            end
            if (bus.frame_err) begin
                checks++;
                if (exp_ferr > 0) begin
                    exp_ferr--;
                    passed++;
                end else begin
                    $display("FAIL unexpected_frame_err: got pulse, expected none");
                end
            end
            if (bus.overrun) begin
                checks++;
                if (exp_ovr > 0) begin
                    exp_ovr--;
                    passed++;
                end else begin
                    $display("FAIL unexpected_overrun: got pulse, expected none");
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         bc;

        bus.data_ready = 1'b1;
        step(5);
        check("rst_data", 32'(bus.data), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_frame_err", 32'(bus.frame_err), 32'h0);
        check("rst_overrun", 32'(bus.overrun), 32'h0);
        rst = 1'b0;
        step(BIT);

        // Single byte with latency measurement
        model_frame(8'h3C, 1'b1);
        fork
            send_frame(8'h3C, 1'b1, BIT);
            measure_latency();
        join
        step(BIT);

        // Short low glitch must abort in START
        rx_in = 1'b0;
        step(BIT * 200 / 864);
        rx_in = 1'b1;
        step(2 * BIT);
        check("glitch_no_valid", 32'(bus.data_valid), 32'h0);

        // Bad stop bit, then line stuck low: one frame_err, no retrigger
        frame(8'hA5, 1'b0, BIT);
        step(20 * BIT);
        check("stuck_low_no_valid", 32'(bus.data_valid), 32'h0);
        check("ferr_consumed", 32'(exp_ferr), 32'h0);
        rx_in = 1'b1;
        step(2 * BIT);

        // Back-to-back with consumer stalled: overrun, first byte held
        bus.data_ready = 1'b0;
        frame(8'h55, 1'b1, BIT);
        frame(8'hAA, 1'b1, BIT);
        step(BIT);
        check("held_data", 32'(bus.data), 32'h55);
        check("held_valid", 32'(bus.data_valid), 32'h1);
        check("ovr_consumed", 32'(exp_ovr), 32'h0);
        bus.data_ready = 1'b1;
        model_full = 1'b0;
        step(1);
        check("accept_drops_valid", 32'(bus.data_valid), 32'h0);
        check("accept_keeps_data", 32'(bus.data), 32'h55);
        step(BIT);

        // Extremes at nominal and +/-2% baud
        frame(8'h00, 1'b1, BIT);
        frame(8'hFF, 1'b1, BIT);
        step(BIT);
        frame(8'h00, 1'b1, BIT_FAST);
        frame(8'hFF, 1'b1, BIT_FAST);
        step(BIT);
        frame(8'h00, 1'b1, BIT_SLOW);
        frame(8'hFF, 1'b1, BIT_SLOW);
        step(BIT);
        check("last_data_before_rst", 32'(bus.data), 32'hFF);

        // Reset mid-DATA after 4 bits
        rx_in = 1'b0;
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            step(BIT);
        end
        step(BIT / 2);
        rst = 1'b1;
        rx_in = 1'b1;
        step(1);
        check("midrst_data", 32'(bus.data), 32'h0);
        check("midrst_valid", 32'(bus.data_valid), 32'h0);
        check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
        check("midrst_overrun", 32'(bus.overrun), 32'h0);
        rst = 1'b0;
        step(2 * BIT);
        frame(8'h81, 1'b1, BIT);
        step(BIT);

        // Randomized frames, stop errors and baud offsets
        for (int n = 0; n < 8; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       bc = BIT_FAST;
                1:       bc = BIT_SLOW;
                default: bc = BIT;
            endcase
            frame(b, ok, bc);
            if (!ok) begin
                rx_in = 1'b1;
                step(BIT);
            end else begin
                step($urandom_range(1, BIT));
            end
        end
        step(2 * BIT);

        check("bytes_outstanding", 32'(data_q.size()), 32'h0);
        check("ferr_outstanding", 32'(exp_ferr), 32'h0);
        check("ovr_outstanding", 32'(exp_ovr), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
